// File: rtl/bloom_pkg.sv
// Shared types and helpers for the Bloom-filter engine.
//   op_e    : request opcode (INSERT / QUERY / CLEAR / ILLEGAL)
//   state_e : engine FSM states
//   GOLDEN  : per-hash mixing constant
//   hash_fold(): XOR-folds a key-wide value down to an index-wide value
package bloom_pkg;

    typedef enum logic [1:0] {
        OP_INSERT  = 2'd0,
        OP_QUERY   = 2'd1,
        OP_CLEAR   = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT_CLR,
        ST_IDLE,
        ST_HASH,
        ST_RD,
        ST_MOD,
        ST_CLR,
        ST_RESP
    } state_e;

    localparam logic [31:0] GOLDEN     = 32'h9E3779B9;
    localparam int unsigned MAX_KEY_W  = 256;
    localparam int unsigned MAX_ADDR_W = 32;

    // XOR of all addr_w-bit slices of x; x must be zero above key_w so the
    // top slice is implicitly zero-padded.
    function automatic logic [MAX_ADDR_W-1:0] hash_fold(input logic [MAX_KEY_W-1:0] x,
                                                        input int unsigned key_w,
                                                        input int unsigned addr_w);
        logic [MAX_ADDR_W-1:0] h;
        logic [MAX_ADDR_W-1:0] mask;
        mask = (MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1);
        h    = '0;
        for (int unsigned s = 0; s < MAX_KEY_W; s++) begin
            if (s * addr_w < key_w)
                h = h ^ (MAX_ADDR_W'(x >> (s * addr_w)) & mask);
        end
        return h;
    endfunction

endpackage

// File: rtl/bloom_filter_engine_if.sv
// Request/response handshake bundle for bloom_filter_engine.
//   req_valid/req_ready/req_op/req_key : request channel (master -> engine)
//   rsp_valid/rsp_ready/rsp_hit/rsp_err: response channel (engine -> master)
interface bloom_filter_engine_if #(
    parameter int unsigned KEY_W = 72
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [KEY_W-1:0] req_key;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_err
    );
endinterface

// File: rtl/bloom_hash_k.sv
// Combinational K-way key hasher.
//   key    in  KEY_W              key to hash
//   hashes out NUM_HASH x ADDR_W  bit-array indices, hashes[i] = h_i
// h_i = fold(rotl(key, 7*i mod KEY_W) ^ replicate32(GOLDEN*(i+1))).
module bloom_hash_k
    import bloom_pkg::*;
#(
    parameter int unsigned KEY_W    = 72,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned NUM_HASH = 7
) (
    input  logic [KEY_W-1:0]                   key,
    output logic [NUM_HASH-1:0][ADDR_W-1:0]    hashes
);
    localparam int unsigned REPS = (KEY_W + 31) / 32;

    for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_hash
        localparam int unsigned ROT = (7 * gi) % KEY_W;
        localparam logic [31:0] MIX = 32'(GOLDEN * 32'(gi + 1));

        logic [KEY_W-1:0]    rot;
        logic [REPS*32-1:0]  rep_full;
        logic [KEY_W-1:0]    x;

        assign rot      = (key << ROT) | (key >> (KEY_W - ROT));
        assign rep_full = {REPS{MIX}};
        assign x        = rot ^ rep_full[KEY_W-1:0];
        assign hashes[gi] = ADDR_W'(hash_fold(MAX_KEY_W'(x), KEY_W, ADDR_W));
    end
endmodule

// File: rtl/bloom_filter_engine.sv
// Bloom-filter engine: NUM_HASH hashes per key over a 2**ADDR_W-bit array
// stored as DEPTH words of WORD_W bits. Supports INSERT (reports prior
// membership), QUERY and CLEAR over a valid/ready request/response bundle.
//   clka       in   clock
//   rst_n      in   async active-low reset; always followed by a full array sweep
//   bus        slave request/response handshake bundle
//   busy       out  high in every state except IDLE
//   fill_count out  INSERTs with hit=0 since last clear, saturating
module bloom_filter_engine
    import bloom_pkg::*;
#(
    parameter int unsigned KEY_W    = 72,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned NUM_HASH = 7,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clka,
    input  logic                  rst_n,
    bloom_filter_engine_if.slave  bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      fill_count
);
    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned WA_W  = ADDR_W - BIT_W;
    localparam int unsigned DEPTH = 2 ** WA_W;
    localparam int unsigned J_W   = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;

    state_e                         state;
    op_e                            op_q;
    logic [KEY_W-1:0]               key_q;
    logic [NUM_HASH-1:0][ADDR_W-1:0] hash_w;
    logic [NUM_HASH-1:0][ADDR_W-1:0] hash_q;
    logic [J_W-1:0]                 j_q;
    logic                           allset_q;
    logic [WA_W-1:0]                idx_q;

    logic [WORD_W-1:0]              mem [DEPTH];
    logic [WORD_W-1:0]              rd_data;
    logic                           mem_we;
    logic [WA_W-1:0]                mem_waddr;
    logic [WORD_W-1:0]              mem_wdata;

    logic [ADDR_W-1:0]              cur_h;
    logic [WA_W-1:0]                cur_word;
    logic [BIT_W-1:0]               cur_bit;
    logic                           cur_set;
    logic                           last_idx;
    logic                           last_j;

    bloom_hash_k #(
        .KEY_W    (KEY_W),
        .ADDR_W   (ADDR_W),
        .NUM_HASH (NUM_HASH)
    ) u_hash (
        .key    (key_q),
        .hashes (hash_w)
    );

    assign cur_h    = hash_q[j_q];
    assign cur_word = cur_h[ADDR_W-1:BIT_W];
    assign cur_bit  = cur_h[BIT_W-1:0];
    assign cur_set  = rd_data[cur_bit];
    assign last_idx = (idx_q == WA_W'(DEPTH - 1));
    assign last_j   = (j_q == J_W'(NUM_HASH - 1));

    // Single write port: sweep/clear zeroing or the INSERT read-modify-write.
    // The MOD write lands at the end of MOD, so the following RD already sees it.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = '0;
        case (state)
            ST_INIT_CLR, ST_CLR: mem_we = 1'b1;
            ST_MOD: begin
                if (op_q == OP_INSERT) begin
                    mem_we    = 1'b1;
                    mem_waddr = cur_word;
                    mem_wdata = rd_data | (WORD_W'(1) << cur_bit);
                end
            end
            default: ;
        endcase
    end

    // Storage is deliberately not reset; the sweep makes it valid.
    always_ff @(posedge clka) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        if (state == ST_RD)
            rd_data <= mem[cur_word];
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT_CLR;
            op_q          <= OP_INSERT;
            key_q         <= '0;
            hash_q        <= '0;
            j_q           <= '0;
            allset_q      <= 1'b1;
            idx_q         <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b1;
            fill_count    <= '0;
        end else begin
            case (state)
                ST_INIT_CLR: begin
                    idx_q <= idx_q + 1'b1;
                    if (last_idx) begin
                        idx_q         <= '0;
                        state         <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= op_e'(bus.req_op);
                        key_q         <= bus.req_key;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        case (op_e'(bus.req_op))
                            OP_INSERT, OP_QUERY: state <= ST_HASH;
                            OP_CLEAR: begin
                                idx_q <= '0;
                                state <= ST_CLR;
                            end
                            default: begin
                                state         <= ST_RESP;
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_hit   <= 1'b0;
                                bus.rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_HASH: begin
                    hash_q   <= hash_w;
                    j_q      <= '0;
                    allset_q <= 1'b1;
                    state    <= ST_RD;
                end
                ST_RD: state <= ST_MOD;
                ST_MOD: begin
                    if (op_q == OP_QUERY && !cur_set) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_hit   <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                    end else if (last_j) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_hit   <= allset_q & cur_set;
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        j_q      <= j_q + 1'b1;
                        allset_q <= allset_q & cur_set;
                        state    <= ST_RD;
                    end
                end
                ST_CLR: begin
                    idx_q <= idx_q + 1'b1;
                    if (last_idx) begin
                        idx_q         <= '0;
                        fill_count    <= '0;
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_hit   <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        if (op_q == OP_INSERT && !bus.rsp_hit && fill_count != '1)
                            fill_count <= fill_count + 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_hit   <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT_CLR;
            endcase
        end
    end
endmodule

// File: tb/tb_bloom_filter_engine.sv
// Scoreboard testbench for bloom_filter_engine: a driver applies requests and
// pushes the reference model's expected response; a monitor pops and compares.
module tb_bloom_filter_engine;
    import bloom_pkg::*;

    localparam int unsigned KEY_W    = 72;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned NUM_HASH = 7;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned NBITS    = 1 << ADDR_W;
    localparam int unsigned DEPTH    = NBITS / WORD_W;
    localparam int unsigned NKEYS    = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] fill_count;

    bloom_filter_engine_if #(.KEY_W(KEY_W)) bus ();

    bloom_filter_engine #(
        .KEY_W    (KEY_W),
        .ADDR_W   (ADDR_W),
        .NUM_HASH (NUM_HASH),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clka       (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic             hit;
        logic             err;
        int unsigned      lat;
        logic [CNT_W-1:0] fill;
        int unsigned      t;
    } exp_t;

    exp_t        sb[$];
    bit          bits[NBITS];
    int unsigned mfill = 0;

    function automatic logic [ADDR_W-1:0] ref_hash(input logic [KEY_W-1:0] key, input int unsigned i);
        logic [31:0]       mix;
        logic [KEY_W-1:0]  x;
        logic [ADDR_W-1:0] h;
        int unsigned       r;
        mix = 32'h9E3779B9 * (i + 1);
        r   = (7 * i) % KEY_W;
        for (int unsigned b = 0; b < KEY_W; b++) x[(b + r) % KEY_W] = key[b];
        for (int unsigned b = 0; b < KEY_W; b++) x[b] = x[b] ^ mix[b % 32];
        h = '0;
        for (int unsigned b = 0; b < KEY_W; b++) h[b % ADDR_W] = h[b % ADDR_W] ^ x[b];
        return h;
    endfunction

    function automatic void model(input logic [1:0] op, input logic [KEY_W-1:0] key, output exp_t e);
        logic [ADDR_W-1:0] h;
        e.hit  = 1'b0;
        e.err  = 1'b0;
        e.t    = 0;
        e.fill = CNT_W'(mfill);
        e.lat  = 2 + 2 * NUM_HASH;
        case (op)
            2'd0: begin
                e.hit = 1'b1;
                for (int unsigned i = 0; i < NUM_HASH; i++) begin
                    h = ref_hash(key, i);
                    if (!bits[h]) e.hit = 1'b0;
                    bits[h] = 1'b1;
                end
                if (!e.hit && mfill < (1 << CNT_W) - 1) mfill++;
            end
            2'd1: begin
                e.hit = 1'b1;
                for (int unsigned i = 0; i < NUM_HASH; i++) begin
                    h = ref_hash(key, i);
                    if (!bits[h]) begin
                        e.hit = 1'b0;
                        e.lat = 4 + 2 * i;
                        break;
                    end
                end
            end
            2'd2: begin
                foreach (bits[k]) bits[k] = 1'b0;
                mfill  = 0;
                e.fill = '0;
                e.lat  = 1 + DEPTH;
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
    endfunction

    // ---------------- monitor ----------------
    bit seen = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && !seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_hit", 64'(bus.rsp_hit), 64'(e.hit));
                    check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    check("rsp_latency", 64'(cyc - e.t), 64'(e.lat));
                    check("fill_at_rsp", 64'(fill_count), 64'(e.fill));
                end
            end
            seen = bus.rsp_valid;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [KEY_W-1:0] key);
        exp_t        e;
        int unsigned n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 64'd0, 64'd1);
            return;
        end
        model(op, key, e);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_key   = key;
        @(posedge clk);
        #1;
        e.t = cyc - 1;
        sb.push_back(e);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || !bus.req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size() == 0 && bus.req_ready), 64'd1);
    endtask

    task automatic peek(input string name);
        logic [WORD_W-1:0] ew;
        int                bad = 0;
        for (int unsigned w = 0; w < DEPTH; w++) begin
            for (int unsigned b = 0; b < WORD_W; b++) ew[b] = bits[w * WORD_W + b];
            if (dut.mem[w] !== ew) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    task automatic release_and_sweep(input string name);
        int unsigned n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 200);
        check(name, 64'(n), 64'(DEPTH));
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        return KEY_W'({$urandom, $urandom, $urandom});
    endfunction

    logic [KEY_W-1:0] keys[NKEYS];

    // ---------------- stimulus ----------------
    initial begin
        logic [KEY_W-1:0] k0;
        int unsigned      n;
        int               stable_bad;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b1;

        // Reset values and sweep length
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_fill", 64'(fill_count), 64'd0);
        release_and_sweep("sweep_cycles");
        check("idle_busy", 64'(busy), 64'd0);

        // Empty-filter query and the single-key insert/query/re-insert sequence
        issue(2'd1, '0);
        k0 = 72'h01_2345_6789_ABCD_EF01;
        issue(2'd0, k0);
        drain();
        check("fill_after_first", 64'(fill_count), 64'd1);
        issue(2'd1, k0);
        issue(2'd0, k0);
        drain();
        check("fill_after_reinsert", 64'(fill_count), 64'd1);

        // Bulk insert then query: no false negatives, array matches model
        for (int unsigned i = 0; i < NKEYS; i++) begin
            keys[i] = rand_key();
            issue(2'd0, keys[i]);
        end
        for (int unsigned i = 0; i < NKEYS; i++) issue(2'd1, keys[i]);
        drain();
        check("fill_after_bulk", 64'(fill_count), 64'(mfill));
        peek("array_after_bulk");

        // Response backpressure
        bus.rsp_ready = 1'b0;
        issue(2'd1, keys[5]);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        stable_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.req_ready !== 1'b0)
                stable_bad++;
        end
        check("bp_stable", 64'(stable_bad), 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(bus.req_ready), 64'd1);
        check("bp_release_valid", 64'(bus.rsp_valid), 64'd0);

        // Illegal op leaves the array alone
        issue(2'd3, rand_key());
        drain();
        peek("array_after_illegal");

        // Random mix over a small key pool
        for (int unsigned i = 0; i < 300; i++) begin
            n = $urandom_range(0, 19);
            issue((n < 9) ? 2'd0 : (n < 19) ? 2'd1 : 2'd3, keys[$urandom_range(0, 63)] ^ KEY_W'($urandom_range(0, 3)));
        end
        drain();
        peek("array_after_mix");

        // CLEAR, then previously inserted keys miss
        issue(2'd2, '0);
        drain();
        check("fill_after_clear", 64'(fill_count), 64'd0);
        for (int unsigned i = 0; i < 8; i++) issue(2'd1, keys[i]);
        issue(2'd1, k0);
        drain();
        peek("array_after_clear");

        // Refill a bit, then reset in the middle of an INSERT
        for (int unsigned i = 0; i < 20; i++) issue(2'd0, keys[i]);
        drain();
        k0 = rand_key();
        issue(2'd0, k0);
        n = 0;
        while (!(dut.state == ST_MOD && dut.j_q == 3) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_mod_j3", 64'(dut.state == ST_MOD && dut.j_q == 3), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_ready", 64'(bus.req_ready), 64'd0);
        check("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("async_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        check("async_busy", 64'(busy), 64'd1);
        check("async_fill", 64'(fill_count), 64'd0);
        sb.delete();
        foreach (bits[k]) bits[k] = 1'b0;
        mfill = 0;
        repeat (2) @(negedge clk);
        release_and_sweep("resweep_cycles");
        issue(2'd1, k0);
        issue(2'd1, keys[3]);
        drain();
        peek("array_after_resweep");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
